serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's single-bit full_adder cell (a, b, cin -> c, s).
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry.
- Presents sum and carry-out over a valid/ready output handshake. Sits between an operand source and any result consumer, trading latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  in  1  system clock; one clock, all state rising-edge triggered.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  A+B+cin, low WIDTH bits.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1 (decoded from IDLE), out_valid=0, sum=0, cout=0, busy=0, carry reg=0, counter=0, operand shift regs=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture a, b into shift regs; carry<=cin; counter<=0; go RUN.
- FSM RUN:
  - in_ready=0; in_valid ignored and a/b may change freely.
  - Each edge: fa inputs = a_sh[0], b_sh[0], carry. Sum-shift reg <= {s, sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1 (zero fill); carry<=c; counter++.
  - When counter==WIDTH-1 at an edge, that edge completes bit WIDTH-1: go DONE.
- FSM DONE:
  - out_valid=1; sum=sum_sh, cout=carry, both held stable while out_valid && !out_ready.
  - On out_ready at an edge: go IDLE, out_valid<=0.
- Latency: operands accepted at edge 0 -> out_valid high after edge WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles (no accept in DONE).
- sum/cout outputs are registered and update only on entry to DONE; they retain the last result in IDLE/RUN.
- Async reset mid-RUN or mid-DONE: immediately returns to reset values; partial result discarded, no out_valid pulse.
- out_ready high while not in DONE has no effect. in_valid held high in IDLE is accepted on the first edge.
- Arithmetic: modulo 2^WIDTH; cout is the true carry. No signed interpretation inside the block.

Optional Feature:
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1: b is captured bit-inverted, carry initialised to 1 (cin ignored), giving A-B. cout=1 means no borrow (A>=B unsigned).
  - When sub=0: add as normal.
- Not defined: no sub port; addition only.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constants SA_MIN_WIDTH=2, SA_MAX_WIDTH=64.
- One sub-module: the existing full_adder cell, instantiated once for the per-bit datapath.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0 -> out_valid after 8 edges, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0; release -> IDLE next edge, in_ready=1.
- in_valid toggled with a=0xAA during RUN -> ignored, original result unaffected; back-to-back ops with out_ready=1 -> one result per 10 cycles.
- rst_n pulled low after 3 RUN cycles -> out_valid=0, sum=0, cout=0 immediately; next op 0x12+0x34 -> 0x46, cout=0.
- SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and width limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

  localparam int SA_MIN_WIDTH = 2;
  localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell: s = a ^ b ^ cin, c = majority(a, b, cin).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic c,
  output logic s
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB-first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns the operation into A-B.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  if (WIDTH < SA_MIN_WIDTH || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of supported range");
  end

  sa_state_e        state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] sum_sh_reg, sum_sh_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             sub_en;
  logic [WIDTH-1:0] b_cap;
  logic             carry_init;
  logic             fa_c, fa_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so B is inverted on capture and carry seeded with 1.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_b_cap
      assign b_cap[gi] = b[gi] ^ sub_en;
    end
  endgenerate

  assign carry_init = sub_en ? 1'b1 : cin;

  full_adder u_fa (
    .a   (a_sh_reg[0]),
    .b   (b_sh_reg[0]),
    .cin (carry_reg),
    .c   (fa_c),
    .s   (fa_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      sum_sh_reg <= sum_sh_next;
      sum_reg    <= sum_next;
      cout_reg   <= cout_next;
      carry_reg  <= carry_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    sum_sh_next = sum_sh_reg;
    sum_next    = sum_reg;
    cout_next   = cout_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_sh_next  = a;
          b_sh_next  = b_cap;
          carry_next = carry_init;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_sh_next = {fa_s, sum_sh_reg[WIDTH-1:1]};
        a_sh_next   = a_sh_reg >> 1;
        b_sh_next   = b_sh_reg >> 1;
        carry_next  = fa_c;
        cnt_next    = cnt_reg + CNT_W'(1);
        // This edge produces the top bit: publish the result as we enter DONE.
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          sum_next   = {fa_s, sum_sh_reg[WIDTH-1:1]};
          cout_next  = fa_c;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
